xpb_reduce_accum: RTL
=====================

# xpb_reduce_accum

Sequential reduction accumulator that sits directly downstream of the per-segment xpb lookup tables in the modular-square datapath. It takes a product split into a 1024-bit low part and NUM_SEGS 5-bit upper segments, and walks the segments one per cycle. For each segment it presents the segment position and value to the external xpb LUT bank and adds the returned 1024-bit residue into a guarded accumulator. The result is a redundant value congruent to the input modulo N, handed to the next squaring iteration through a valid/ready handshake.

## Interface
- Parameters:
- NUM_SEGS, 16, number of 5-bit upper segments walked per operation
- SEG_BITS, 5, segment width; must match the LUT select width
- WORD_BITS, 1024, LUT output and low-part width
- IDX_BITS, $clog2(NUM_SEGS), segment index width
- ACC_BITS, WORD_BITS+5, accumulator width; holds NUM_SEGS+1 full-width terms without overflow
- Ports:
- clk  input  1  single clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand valid
- in_ready  output  1  block can accept an operand; high only in IDLE
- in_low  input  WORD_BITS  low part of product, seeds the accumulator
- in_high  input  NUM_SEGS*SEG_BITS  upper segments; segment k is bits [k*SEG_BITS +: SEG_BITS]
- lut_seg  output  IDX_BITS  segment position driven to the LUT bank mux
- lut_sel  output  SEG_BITS  segment value driven to the LUT data_in
- lut_data  input  WORD_BITS  combinational LUT result for (lut_seg, lut_sel)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_sum  output  ACC_BITS  accumulated result

## Operation
- States: IDLE, ACCUM, DRAIN (only with XPB_ACC_PIPE_EN), DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: acc<=in_low zero-extended, high_reg<=in_high, seg<=0, go ACCUM.
- ACCUM:
  - lut_seg=seg, lut_sel=high_reg[seg].
  - Each cycle the LUT term is added to acc, and seg increments.
  - After seg==NUM_SEGS-1, go to DONE (or to DRAIN when XPB_ACC_PIPE_EN is defined).
- Segments of value 0 are not skipped; the LUT returns 0 and the add still occurs. Cycle count is fixed.
- DONE:
  - out_valid=1, out_sum=acc held stable.
  - On out_ready, go to IDLE on the next edge.
- Outside ACCUM: lut_seg=0, lut_sel=0.
- Arithmetic:
  - Unsigned; every term is zero-extended to ACC_BITS.
  - No modular reduction is performed here; the result is redundant, < (NUM_SEGS+1)*2^WORD_BITS.
- in_valid is ignored outside IDLE. An operand is never dropped because in_ready=0.
- Reset values: state=IDLE, acc=0, seg=0, high_reg=0, out_valid=0, out_sum=0, lut_seg=0, lut_sel=0, in_ready=1.
  - Inputs are ignored while rst=1.
- Reset mid-ACCUM or DONE:
  - The operation is abandoned with no output.
  - The next operand is accepted normally after rst deasserts.

## Timing
- The operand is accepted at edge T.
- Without the macro:
  - ACCUM occupies cycles T+1..T+NUM_SEGS.
  - out_valid rises at edge T+NUM_SEGS+1 (17 cycles at default).
- With the macro, out_valid rises at T+NUM_SEGS+2.
- Earliest new acceptance: one cycle after out_valid&&out_ready (IDLE for at least one cycle).
- Throughput is one operation per NUM_SEGS+2 cycles (NUM_SEGS+3 with the macro).
- lut_seg/lut_sel are registered-state-derived.
  - lut_data must settle within the same cycle (single-cycle combinational LUT path).

## Configuration
- XPB_ACC_PIPE_EN defined:
  - lut_data is captured into a WORD_BITS register each ACCUM cycle.
  - The add uses the registered term one cycle later.
  - DRAIN state adds the final term.
  - Latency increases by 1; the LUT-to-adder path is cut.
- XPB_ACC_PIPE_EN undefined:
  - lut_data is added directly in the same cycle.
  - There is no DRAIN state.
- The numerical result is identical in both builds.

## Test plan
- in_high=0, in_low=0x1234: out_valid after 17 cycles (18 with macro); out_sum=0x1234.
- in_low=0, segment 0=5'h01, other segments 0, bench LUT model returns V for (0,1): out_sum=V, and lut_seg steps 0..15 once each.
- All segments 5'h1F, in_low=2^1024-1, LUT model returns 2^1024-1 for every select: out_sum=17*(2^1024-1) with no wrap in the top bits.
- out_ready held low 10 cycles in DONE:
  - out_valid stays 1, out_sum stays unchanged, in_ready=0, and in_valid pulses are ignored.
  - After release, IDLE follows and the next operand is accepted.
- rst asserted while seg=7:
  - Outputs reach reset values immediately; out_valid never pulses.
  - The next operand after reset yields the correct sum.
- Back-to-back: two operands with in_valid held high complete with the correct sums, and the second is accepted exactly 2 cycles after the first out_valid rises when out_ready=1.

Source files
------------

// File: rtl/xpb_reduce_accum_if.sv
// Operand, LUT-bank and result signals of the xpb reduction accumulator, bundled for port use.
// master = operand source / LUT bank / result consumer side, slave = the accumulator.
interface xpb_reduce_accum_if #(
    parameter int NUM_SEGS  = 16,
    parameter int SEG_BITS  = 5,
    parameter int WORD_BITS = 1024,
    parameter int IDX_BITS  = $clog2(NUM_SEGS),
    parameter int ACC_BITS  = WORD_BITS + 5
);
    logic                          in_valid;
    logic                          in_ready;
    logic [WORD_BITS-1:0]          in_low;
    logic [NUM_SEGS*SEG_BITS-1:0]  in_high;
    logic [IDX_BITS-1:0]           lut_seg;
    logic [SEG_BITS-1:0]           lut_sel;
    logic [WORD_BITS-1:0]          lut_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [ACC_BITS-1:0]           out_sum;

    modport master (
        output in_valid, in_low, in_high, lut_data, out_ready,
        input  in_ready, lut_seg, lut_sel, out_valid, out_sum
    );

    modport slave (
        input  in_valid, in_low, in_high, lut_data, out_ready,
        output in_ready, lut_seg, lut_sel, out_valid, out_sum
    );
endinterface

// File: rtl/xpb_reduce_accum.sv
// Walks the upper product segments through the external xpb LUT bank and sums the residues onto the low part.
// Optional macro XPB_ACC_PIPE_EN registers the LUT term, adding a DRAIN state and one cycle of latency.
module xpb_reduce_accum #(
    parameter int NUM_SEGS  = 16,
    parameter int SEG_BITS  = 5,
    parameter int WORD_BITS = 1024,
    parameter int IDX_BITS  = $clog2(NUM_SEGS),
    parameter int ACC_BITS  = WORD_BITS + 5
) (
    input  logic              clk,
    input  logic              rst,
    xpb_reduce_accum_if.slave bus
);
`ifdef XPB_ACC_PIPE_EN
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
`endif

    state_t                        state_reg;
    state_t                        state_next;
    logic [ACC_BITS-1:0]           acc_reg;
    logic [IDX_BITS-1:0]           seg_reg;
    logic [NUM_SEGS*SEG_BITS-1:0]  high_reg;
    logic [ACC_BITS-1:0]           addend;
    logic                          last_seg;

    assign last_seg = (seg_reg == IDX_BITS'(NUM_SEGS - 1));

`ifdef XPB_ACC_PIPE_EN
    // Term register cuts the LUT-to-adder path; it is cleared on accept so the
    // first ACCUM cycle adds zero and DRAIN adds the last segment's term.
    logic [WORD_BITS-1:0] term_reg;
    assign addend = ACC_BITS'(term_reg);
`else
    assign addend = ACC_BITS'(bus.lut_data);
`endif

    always_comb begin
        state_next    = state_reg;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_sum   = '0;
        bus.lut_seg   = '0;
        bus.lut_sel   = '0;
        case (state_reg)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                bus.lut_seg = seg_reg;
                bus.lut_sel = high_reg[seg_reg*SEG_BITS +: SEG_BITS];
                if (last_seg) begin
`ifdef XPB_ACC_PIPE_EN
                    state_next = DRAIN;
`else
                    state_next = DONE;
`endif
                end
            end
`ifdef XPB_ACC_PIPE_EN
            DRAIN: begin
                state_next = DONE;
            end
`endif
            DONE: begin
                bus.out_valid = 1'b1;
                bus.out_sum   = acc_reg;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            seg_reg   <= '0;
            high_reg  <= '0;
`ifdef XPB_ACC_PIPE_EN
            term_reg  <= '0;
`endif
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        acc_reg  <= ACC_BITS'(bus.in_low);
                        high_reg <= bus.in_high;
                        seg_reg  <= '0;
`ifdef XPB_ACC_PIPE_EN
                        term_reg <= '0;
`endif
                    end
                end
                ACCUM: begin
                    // Zero-valued segments still take their cycle so latency is fixed.
                    acc_reg <= acc_reg + addend;
                    seg_reg <= seg_reg + IDX_BITS'(1);
`ifdef XPB_ACC_PIPE_EN
                    term_reg <= bus.lut_data;
`endif
                end
`ifdef XPB_ACC_PIPE_EN
                DRAIN: begin
                    acc_reg <= acc_reg + addend;
                end
`endif
                default: begin
                end
            endcase
        end
    end
endmodule
